proj_select_ctrl: RTL and testbench
===================================

Name: proj_select_ctrl

Overview:
- Upstream control stage for the 16-way project output multiplexer; produces the mux select instead of passing the raw Wishbone select straight through.
- Qualifies a requested project number, blanks the shared output pins, switches the select, then pulses a reset to the newly selected project.
- Prevents glitchy select changes and mixed-project output on the shared 16-bit io_out bus.

Parameters:
- NPROJ, 16, number of selectable projects (one-hot reset width).
- SELW, 4, select width; NPROJ == 2**SELW.
- STABLE_CYCLES, 3, consecutive equal samples required to accept a request (>=1).
- BLANK_CYCLES, 2, cycles the output is blanked before the select changes (>=1).
- RST_CYCLES, 4, cycles the new project's reset is held (>=1).

Ports:
- wb_clk_i, input, 1, sole clock; all logic on the rising edge.
- wb_rst_i, input, 1, synchronous active-high reset.
- sel_req, input, SELW, requested project; driven by wbs_sel_i; sampled every edge.
- mux_sel, output, SELW, registered select to the output mux.
- proj_rst, output, NPROJ, one-hot active-high reset to the projects.
- out_blank, output, 1, when 1 the top level forces io_out to 0.
- busy, output, 1, high in any state other than ACTIVE.
- switch_count, output, 8, number of completed switches; saturates at 255.

Behaviour:
- All outputs are registered. There are no combinational paths from sel_req.
- Reset, sampled with wb_rst_i=1 at an edge: mux_sel=0, switch_count=0, cnt=0, state=SWITCH. Outputs during reset are proj_rst=0x0001, out_blank=1, busy=1.
- The first SWITCH after reset lasts RST_CYCLES cycles from reset deassertion and does not increment switch_count.
- States: ACTIVE, QUALIFY, BLANK, SWITCH.
- ACTIVE:
  - Outputs: out_blank=0, proj_rst=0, busy=0.
  - If sel_req != mux_sel: capture cand=sel_req, set cnt=1, go to QUALIFY. If STABLE_CYCLES==1, go directly to BLANK.
- QUALIFY:
  - Outputs: out_blank=0, busy=1, mux_sel unchanged.
  - sel_req == cand: cnt++. When cnt reaches STABLE_CYCLES, go to BLANK with cnt=0.
  - sel_req == mux_sel: abandon the request, return to ACTIVE, no side effects.
  - sel_req is any other value: cand=sel_req, cnt=1, stay in QUALIFY.
- BLANK:
  - Outputs: out_blank=1 for exactly BLANK_CYCLES cycles, mux_sel still the old value.
  - On exit: mux_sel<=cand, cnt=0, go to SWITCH.
- SWITCH:
  - Outputs: out_blank=1, proj_rst has only bit mux_sel set, for exactly RST_CYCLES cycles.
  - On exit: switch_count++ (saturating), go to ACTIVE.
- Total blanking per switch is BLANK_CYCLES+RST_CYCLES cycles. Accept latency is STABLE_CYCLES edges after the first differing sample.
- sel_req is ignored in BLANK and SWITCH. A request still differing on return to ACTIVE is requalified from scratch.
- Reset mid-operation, in any state: the sequence aborts, mux_sel returns to 0, and the post-reset SWITCH sequence runs. A pending candidate is discarded.
- cnt width is clog2 of the maximum of the three cycle parameters, plus 1. It never wraps.

Decomposition:
- Package proj_sel_pkg holds:
  - the state enum (ACTIVE, QUALIFY, BLANK, SWITCH);
  - SELW, NPROJ and the default cycle constants;
  - a one-hot decode function.
- Single module; no sub-module is warranted.
- The counter and the saturating switch_count are inline.

Test Plan:
- Reset: hold wb_rst_i for 2 cycles, release with sel_req=0. Expect proj_rst=0x0001 and out_blank=1 for 4 cycles, then ACTIVE with out_blank=0, mux_sel=0, switch_count=0.
- Clean switch: sel_req 0->2 and held.
  - Edge 3: state BLANK.
  - 2 cycles: out_blank=1 with mux_sel=0.
  - Then mux_sel=2 and proj_rst=0x0004 for 4 cycles.
  - out_blank drops 6 cycles after entering BLANK; switch_count=1.
- Glitch rejection: from mux_sel=2, sel_req=5 for 2 cycles then back to 2. Expect mux_sel=2, out_blank never 1, proj_rst=0, switch_count unchanged, busy high for 2 cycles.
- Candidate change: sel_req=7 for 2 cycles, then 9 held. Expect BLANK entered on the 3rd edge of 9, final mux_sel=9, proj_rst=0x0200, and no switch to 7.
- Request during SWITCH: change sel_req to 1 while in SWITCH toward 9. Expect the switch to 9 to complete, then requalification, then a switch to 1; switch_count increments by 2 total.
- Reset mid-BLANK: assert wb_rst_i for 1 cycle during BLANK. Expect mux_sel=0, proj_rst=0x0001 for 4 cycles, and no switch_count increment for the aborted switch.

Source files
------------

// File: rtl/proj_sel_pkg.sv
// Shared types and defaults for the project-select controller: state encoding,
// select/reset widths, default cycle counts and the one-hot reset decode.
package proj_sel_pkg;

    localparam int SELW_DEF          = 4;
    localparam int NPROJ_DEF         = 16;
    localparam int STABLE_CYCLES_DEF = 3;
    localparam int BLANK_CYCLES_DEF  = 2;
    localparam int RST_CYCLES_DEF    = 4;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_BLANK   = 2'd2,
        ST_SWITCH  = 2'd3
    } state_t;

    function automatic logic [NPROJ_DEF-1:0] onehot(input logic [SELW_DEF-1:0] idx);
        logic [NPROJ_DEF-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/proj_select_ctrl.sv
// Qualifies a requested project number, blanks the shared outputs, switches the
// mux select and pulses reset to the new project. All outputs are registered.
module proj_select_ctrl
    import proj_sel_pkg::*;
#(
    parameter int NPROJ         = NPROJ_DEF,
    parameter int SELW          = SELW_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int BLANK_CYCLES  = BLANK_CYCLES_DEF,
    parameter int RST_CYCLES    = RST_CYCLES_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [SELW-1:0]   sel_req,
    output logic [SELW-1:0]   mux_sel,
    output logic [NPROJ-1:0]  proj_rst,
    output logic              out_blank,
    output logic              busy,
    output logic [7:0]        switch_count
);

    localparam int MAX_AB = (STABLE_CYCLES > BLANK_CYCLES) ? STABLE_CYCLES : BLANK_CYCLES;
    localparam int MAXC   = (MAX_AB > RST_CYCLES) ? MAX_AB : RST_CYCLES;
    localparam int CNTW   = $clog2(MAXC) + 1;

    state_t            state, state_n;
    logic [CNTW-1:0]   cnt, cnt_n;
    logic [SELW-1:0]   cand, cand_n;
    logic [SELW-1:0]   mux_n;
    logic [7:0]        sc_n;
    // Set only for switches entered through BLANK, so the post-reset SWITCH is not counted.
    logic              counted, counted_n;
    logic              blank_n, busy_n;
    logic [NPROJ-1:0]  prst_n;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cand_n    = cand;
        mux_n     = mux_sel;
        sc_n      = switch_count;
        counted_n = counted;
        case (state)
            ST_ACTIVE: begin
                if (sel_req != mux_sel) begin
                    cand_n = sel_req;
                    if (STABLE_CYCLES == 1) begin
                        state_n = ST_BLANK;
                        cnt_n   = '0;
                    end else begin
                        state_n = ST_QUALIFY;
                        cnt_n   = CNTW'(1);
                    end
                end
            end
            ST_QUALIFY: begin
                if (sel_req == mux_sel) begin
                    state_n = ST_ACTIVE;
                    cnt_n   = '0;
                end else if (sel_req == cand) begin
                    if (int'(cnt) + 1 >= STABLE_CYCLES) begin
                        state_n = ST_BLANK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNTW'(1);
                    end
                end else begin
                    cand_n = sel_req;
                    cnt_n  = CNTW'(1);
                end
            end
            ST_BLANK: begin
                if (int'(cnt) >= BLANK_CYCLES - 1) begin
                    state_n   = ST_SWITCH;
                    cnt_n     = '0;
                    mux_n     = cand;
                    counted_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
            default: begin
                if (int'(cnt) >= RST_CYCLES - 1) begin
                    state_n   = ST_ACTIVE;
                    cnt_n     = '0;
                    counted_n = 1'b0;
                    if (counted && switch_count != 8'hFF)
                        sc_n = switch_count + 8'd1;
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
        endcase

        blank_n = (state_n == ST_BLANK) || (state_n == ST_SWITCH);
        busy_n  = (state_n != ST_ACTIVE);
        prst_n  = (state_n == ST_SWITCH) ? NPROJ'(onehot(SELW_DEF'(mux_n))) : '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= ST_SWITCH;
            cnt          <= '0;
            cand         <= '0;
            mux_sel      <= '0;
            switch_count <= '0;
            counted      <= 1'b0;
            out_blank    <= 1'b1;
            busy         <= 1'b1;
            proj_rst     <= NPROJ'(1);
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            cand         <= cand_n;
            mux_sel      <= mux_n;
            switch_count <= sc_n;
            counted      <= counted_n;
            out_blank    <= blank_n;
            busy         <= busy_n;
            proj_rst     <= prst_n;
        end
    end

endmodule

// File: tb/tb_proj_select_ctrl.sv
// Bench for proj_select_ctrl: directed scenarios plus random requests, scored
// cycle by cycle against a countdown-window model of the switch sequence.
module tb_proj_select_ctrl;

    localparam int SC = 3;
    localparam int BC = 2;
    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic [3:0]  sel_req;
    logic [3:0]  mux_sel;
    logic [15:0] proj_rst;
    logic        out_blank;
    logic        busy;
    logic [7:0]  switch_count;

    always #5 clk = ~clk;

    proj_select_ctrl #(
        .NPROJ(16), .SELW(4), .STABLE_CYCLES(SC), .BLANK_CYCLES(BC), .RST_CYCLES(RC)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .sel_req     (sel_req),
        .mux_sel     (mux_sel),
        .proj_rst    (proj_rst),
        .out_blank   (out_blank),
        .busy        (busy),
        .switch_count(switch_count)
    );

    typedef struct packed {
        logic [3:0]  mux;
        logic [15:0] prst;
        logic        blank;
        logic        bsy;
        logic [7:0]  sc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Model: a qualifying run of equal requests, then a blanking window of
    // BC+RC cycles; the select flips when RC cycles remain, reset covers those RC.
    int m_cur, m_cand, m_run, m_hold, m_pend, m_sc;
    bit m_count_this;

    function automatic void chk(input string name, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s got=%0d expected=%0d at %0t", name, got, want, $time);
    endfunction

    function automatic void model_step(input bit r, input int s);
        exp_t e;
        if (r) begin
            m_cur = 0; m_hold = RC; m_count_this = 0; m_run = 0; m_sc = 0;
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == RC) begin
                m_cur = m_pend;
                m_count_this = 1;
            end
            if (m_hold == 0 && m_count_this) begin
                if (m_sc < 255) m_sc++;
                m_count_this = 0;
            end
        end else begin
            if (s == m_cur) m_run = 0;
            else if (m_run > 0 && s == m_cand) m_run++;
            else begin
                m_cand = s;
                m_run  = 1;
            end
            if (m_run >= SC) begin
                m_pend = m_cand;
                m_hold = BC + RC;
                m_run  = 0;
            end
        end
        e.mux   = m_cur[3:0];
        e.prst  = (m_hold > 0 && m_hold <= RC) ? (16'(1) << m_cur) : 16'(0);
        e.blank = (m_hold > 0);
        e.bsy   = (m_hold > 0) || (m_run > 0);
        e.sc    = m_sc[7:0];
        exp_q.push_back(e);
    endfunction

    task automatic cyc(input bit r, input int s);
        wb_rst_i = r;
        sel_req  = s[3:0];
        @(posedge clk);
        model_step(r, s);
        @(negedge clk);
    endtask

    task automatic hold_req(input int s, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, s);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mux_sel",      int'(mux_sel),      int'(e.mux));
                chk("proj_rst",     int'(proj_rst),     int'(e.prst));
                chk("out_blank",    int'(out_blank),    int'(e.blank));
                chk("busy",         int'(busy),         int'(e.bsy));
                chk("switch_count", int'(switch_count), int'(e.sc));
            end
        end
    end

    initial begin : driver
        int v, len, r;
        wb_rst_i = 1'b1;
        sel_req  = 4'd0;

        // Reset: 2 cycles held, then the post-reset reset pulse to project 0.
        cyc(1'b1, 0);
        cyc(1'b1, 0);
        chk("rst_proj_rst", int'(proj_rst), 16'h0001);
        hold_req(0, 4);
        hold_req(0, 2);
        chk("rst_done_blank", int'(out_blank), 0);
        chk("rst_done_count", int'(switch_count), 0);

        // Clean switch 0 -> 2.
        hold_req(2, 3);
        chk("clean_blank_mux_old", int'(mux_sel), 0);
        chk("clean_blank_on", int'(out_blank), 1);
        hold_req(2, 2);
        chk("clean_sw_rst", int'(proj_rst), 16'h0004);
        hold_req(2, 6);
        chk("clean_mux", int'(mux_sel), 2);
        chk("clean_count", int'(switch_count), 1);

        // Glitch to 5 for two cycles.
        hold_req(5, 2);
        hold_req(2, 4);
        chk("glitch_mux", int'(mux_sel), 2);
        chk("glitch_count", int'(switch_count), 1);

        // Candidate change 7 -> 9, then a request for 1 arriving mid-SWITCH.
        hold_req(7, 2);
        hold_req(9, 5);
        chk("cand_sw_rst", int'(proj_rst), 16'h0200);
        hold_req(9, 1);
        hold_req(1, 22);
        chk("during_sw_mux", int'(mux_sel), 1);
        chk("during_sw_count", int'(switch_count), 3);

        // Reset in the middle of BLANK toward 6.
        hold_req(6, 4);
        chk("midblank_on", int'(out_blank), 1);
        cyc(1'b1, 6);
        chk("midblank_rst_mux", int'(mux_sel), 0);
        hold_req(0, 8);
        chk("midblank_mux", int'(mux_sel), 0);
        chk("midblank_count", int'(switch_count), 0);

        // Randomised requests with occasional resets.
        v = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) != 0) v = int'($urandom_range(0, 15));
            len = int'($urandom_range(1, 7));
            for (int j = 0; j < len; j++) begin
                r = ($urandom_range(0, 149) == 0) ? 1 : 0;
                cyc(r[0], v);
            end
        end
        hold_req(v, 12);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
